// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences one 256K x 16 async SRAM between video (word reads),
// CPU (byte reads/writes, 64K space plus ramdisk page) and JTAG (word reads/writes).
// Every SRAM strobe is registered, so address, byte enables and data settle
// before we_n falls and stay put until after it rises.
// Optional macro SRAM_ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive video
// grants with the CPU waiting, the CPU wins the next arbitration.
module sram_arbiter #(
  parameter int unsigned RD_WAIT    = 1
`ifdef SRAM_ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [17:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [2:0]  cpu_page,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        jt_req,
  input  logic        jt_we,
  input  logic [17:0] jt_addr,
  input  logic [15:0] jt_wdata,
  output logic        jt_ack,
  output logic [15:0] jt_rdata,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_ACK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_JT} owner_t;

  localparam logic [2:0] RD_LAST = 3'(RD_WAIT);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        hi_q, hi_d;
  logic [2:0]  rd_cnt_q, rd_cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic        ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic        we_n_q, we_n_d, dq_oe_q, dq_oe_d;
  logic        vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, jt_ack_q, jt_ack_d;
  logic [15:0] vid_data_q, vid_data_d, jt_rdata_q, jt_rdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_first, grant_vid, grant_cpu, grant_jt;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_q;

  // Count video grants made while the CPU waits; any CPU grant or idle CPU clears it.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= 3'd0;
    end else if (!cpu_req || (state_q == S_IDLE && grant_cpu)) begin
      starve_q <= 3'd0;
    end else if (state_q == S_IDLE && grant_vid && starve_q != 3'd7) begin
      starve_q <= starve_q + 3'd1;
    end
  end

  assign cpu_first = cpu_req && ({29'd0, starve_q} >= STARVE_MAX);
`else
  assign cpu_first = 1'b0;
`endif

  // Fixed priority vid > cpu > jt, with the CPU promoted when the guard trips.
  assign grant_vid = vid_req && !cpu_first;
  assign grant_cpu = cpu_req && (cpu_first || !vid_req);
  assign grant_jt  = jt_req && !vid_req && !cpu_req;

  // Next-state, grant capture, read-data capture and strobe generation.
  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hi_d        = hi_q;
    rd_cnt_d    = rd_cnt_q;
    addr_d      = addr_q;
    dq_d        = dq_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    jt_rdata_d  = jt_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        rd_cnt_d = 3'd0;
        if (grant_vid) begin
          owner_d = OWN_VID;
          addr_d  = vid_addr;
          ub_n_d  = 1'b0;
          lb_n_d  = 1'b0;
          state_d = S_RD;
        end else if (grant_cpu) begin
          owner_d = OWN_CPU;
          hi_d    = cpu_addr[0];
          addr_d  = {cpu_page, cpu_addr[15:1]};
          ub_n_d  = ~cpu_addr[0];
          lb_n_d  = cpu_addr[0];
          dq_d    = cpu_addr[0] ? {cpu_wdata, 8'h00} : {8'h00, cpu_wdata};
          state_d = cpu_we ? S_WR_SETUP : S_RD;
        end else if (grant_jt) begin
          owner_d = OWN_JT;
          addr_d  = jt_addr;
          ub_n_d  = 1'b0;
          lb_n_d  = 1'b0;
          dq_d    = jt_wdata;
          state_d = jt_we ? S_WR_SETUP : S_RD;
        end
      end
      S_RD: begin
        if (rd_cnt_q == RD_LAST) begin
          unique case (owner_q)
            OWN_VID: vid_data_d  = sram_dq_i;
            OWN_CPU: cpu_rdata_d = hi_q ? sram_dq_i[15:8] : sram_dq_i[7:0];
            OWN_JT:  jt_rdata_d  = sram_dq_i;
            default: ;
          endcase
          state_d = S_ACK;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: state_d = S_WR_HOLD;
      S_WR_HOLD:  state_d = S_ACK;
      S_ACK:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    we_n_d    = (state_d != S_WR_PULSE);
    dq_oe_d   = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
    vid_ack_d = (state_d == S_ACK) && (owner_q == OWN_VID);
    cpu_ack_d = (state_d == S_ACK) && (owner_q == OWN_CPU);
    jt_ack_d  = (state_d == S_ACK) && (owner_q == OWN_JT);
  end

  // State and registered outputs; reset drops we_n/dq_oe asynchronously.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      hi_q        <= 1'b0;
      rd_cnt_q    <= 3'd0;
      addr_q      <= 18'd0;
      dq_q        <= 16'd0;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      jt_ack_q    <= 1'b0;
      vid_data_q  <= 16'd0;
      cpu_rdata_q <= 8'd0;
      jt_rdata_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hi_q        <= hi_d;
      rd_cnt_q    <= rd_cnt_d;
      addr_q      <= addr_d;
      dq_q        <= dq_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      jt_ack_q    <= jt_ack_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      jt_rdata_q  <= jt_rdata_d;
    end
  end

  assign vid_ack    = vid_ack_q;
  assign vid_data   = vid_data_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign jt_ack     = jt_ack_q;
  assign jt_rdata   = jt_rdata_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default instance (RD_WAIT=1) plus an
// RD_WAIT=3 instance, each attached to a byte-enabled SRAM model.
module tb_sram_arbiter;

  logic clk24 = 1'b0;
  always #5 clk24 = ~clk24;
  logic reset_n;

  logic        vid_req, vid_ack, cpu_req, cpu_we, cpu_ack, jt_req, jt_we, jt_ack;
  logic [17:0] vid_addr, jt_addr, sram_addr;
  logic [15:0] vid_data, jt_wdata, jt_rdata, sram_dq_o, sram_dq_i;
  logic [15:0] cpu_addr;
  logic [2:0]  cpu_page;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        sram_dq_oe, sram_we_n, sram_ub_n, sram_lb_n;

  logic        b_vid_req, b_vid_ack, b_cpu_ack, b_jt_ack;
  logic [17:0] b_vid_addr, b_sram_addr;
  logic [15:0] b_vid_data, b_jt_rdata, b_sram_dq_o, b_sram_dq_i;
  logic [7:0]  b_cpu_rdata;
  logic        b_sram_dq_oe, b_sram_we_n, b_sram_ub_n, b_sram_lb_n;

  sram_arbiter dut (
    .clk24(clk24), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_page(cpu_page),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .jt_req(jt_req), .jt_we(jt_we), .jt_addr(jt_addr), .jt_wdata(jt_wdata),
    .jt_ack(jt_ack), .jt_rdata(jt_rdata),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_arbiter #(.RD_WAIT(3)) dut3 (
    .clk24(clk24), .reset_n(reset_n),
    .vid_req(b_vid_req), .vid_addr(b_vid_addr), .vid_ack(b_vid_ack), .vid_data(b_vid_data),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'd0), .cpu_page(3'd0),
    .cpu_wdata(8'd0), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .jt_req(1'b0), .jt_we(1'b0), .jt_addr(18'd0), .jt_wdata(16'd0),
    .jt_ack(b_jt_ack), .jt_rdata(b_jt_rdata),
    .sram_addr(b_sram_addr), .sram_dq_o(b_sram_dq_o), .sram_dq_oe(b_sram_dq_oe),
    .sram_dq_i(b_sram_dq_i), .sram_we_n(b_sram_we_n), .sram_ub_n(b_sram_ub_n), .sram_lb_n(b_sram_lb_n)
  );

  // SRAM models: asynchronous read, byte-enabled write while we_n is low.
  logic [15:0] mem  [0:262143];
  logic [15:0] mem3 [0:262143];
  assign sram_dq_i   = mem[sram_addr];
  assign b_sram_dq_i = mem3[b_sram_addr];

  int          we_low_cnt;
  logic [17:0] cap_addr;
  logic [15:0] cap_dq;
  logic        cap_ub, cap_lb, cap_oe;

  always @(negedge clk24) begin
    if (!sram_we_n) begin
      we_low_cnt = we_low_cnt + 1;
      cap_addr = sram_addr;
      cap_dq   = sram_dq_o;
      cap_ub   = sram_ub_n;
      cap_lb   = sram_lb_n;
      cap_oe   = sram_dq_oe;
      if (sram_dq_oe && !sram_ub_n) mem[sram_addr][15:8] = sram_dq_o[15:8];
      if (sram_dq_oe && !sram_lb_n) mem[sram_addr][7:0]  = sram_dq_o[7:0];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic req_set(input int who, input logic v);
    case (who)
      0: vid_req = v;
      1: cpu_req = v;
      default: jt_req = v;
    endcase
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      0: return vid_ack;
      1: return cpu_ack;
      default: return jt_ack;
    endcase
  endfunction

  // One access from an idle arbiter: checks ack latency and single-cycle ack.
  task automatic access(input int who, input string tag, input int exp_lat);
    int n;
    logic got;
    @(posedge clk24); #1;
    req_set(who, 1'b1);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk24); n++;
      @(negedge clk24); got = ack_of(who);
    end
    req_set(who, 1'b0);
    check({tag, " latency"}, n, exp_lat);
    @(negedge clk24);
    check({tag, " ack pulse"}, {31'd0, ack_of(who)}, 0);
  endtask

  initial begin
    int ord, nacks, multi, vid_cnt, stable, n;
    logic cpu_done, got;

    reset_n = 1'b0;
    vid_req = 0; vid_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_page = 0;
    cpu_wdata = 0; jt_req = 0; jt_we = 0; jt_addr = 0; jt_wdata = 0;
    b_vid_req = 0; b_vid_addr = 0;
    we_low_cnt = 0;
    mem[18'h1091A]  = 16'h005A;
    mem[18'h00200]  = 16'h1357;
    mem3[18'h00100] = 16'hBEEF;

    // Reset state
    repeat (2) @(negedge clk24);
    check("rst acks", {29'd0, vid_ack, cpu_ack, jt_ack}, 0);
    check("rst strobes", {28'd0, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}, 32'hE);
    check("rst addr", {14'd0, sram_addr}, 0);
    check("rst data", {vid_data, cpu_rdata, 8'd0}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk24);

    // CPU byte write to upper half
    cpu_we = 1; cpu_addr = 16'h1235; cpu_page = 3'd2; cpu_wdata = 8'hA5;
    we_low_cnt = 0;
    access(1, "cpu_wr", 4);
    check("cpu_wr we_n low cycles", we_low_cnt, 1);
    check("cpu_wr addr", {14'd0, cap_addr}, 32'h1091A);
    check("cpu_wr ub/lb/oe", {29'd0, cap_ub, cap_lb, cap_oe}, 32'h3);
    check("cpu_wr dq", {16'd0, cap_dq}, 32'hA500);

    // CPU byte reads: upper byte just written, lower byte untouched
    cpu_we = 0;
    access(1, "cpu_rd_hi", 3);
    check("cpu_rd_hi data", {24'd0, cpu_rdata}, 32'hA5);
    cpu_addr = 16'h1234;
    access(1, "cpu_rd_lo", 3);
    check("cpu_rd_lo data", {24'd0, cpu_rdata}, 32'h5A);

    // JTAG word write/read at top of memory
    jt_we = 1; jt_addr = 18'h3FFFF; jt_wdata = 16'hC3E0;
    we_low_cnt = 0;
    access(2, "jt_wr", 4);
    check("jt_wr we_n low cycles", we_low_cnt, 1);
    check("jt_wr addr", {14'd0, cap_addr}, 32'h3FFFF);
    check("jt_wr ub/lb", {30'd0, cap_ub, cap_lb}, 0);
    check("jt_wr dq", {16'd0, cap_dq}, 32'hC3E0);
    jt_we = 0;
    access(2, "jt_rd", 3);
    check("jt_rd data", {16'd0, jt_rdata}, 32'hC3E0);

    // Video read
    vid_addr = 18'h00200;
    access(0, "vid_rd", 3);
    check("vid_rd data", {16'd0, vid_data}, 32'h1357);

    // Collision: all three raise together, reads from known locations
    vid_addr = 18'h00200; cpu_addr = 16'h1235; cpu_page = 3'd2; jt_addr = 18'h3FFFF;
    @(posedge clk24); #1;
    vid_req = 1; cpu_req = 1; jt_req = 1;
    ord = 0; nacks = 0; multi = 0;
    for (int c = 0; c < 40 && nacks < 3; c++) begin
      @(negedge clk24);
      if (32'(vid_ack) + 32'(cpu_ack) + 32'(jt_ack) > 1) multi++;
      if (vid_ack) begin ord = ord * 4 + 1; nacks++; vid_req = 0; end
      if (cpu_ack) begin ord = ord * 4 + 2; nacks++; cpu_req = 0; end
      if (jt_ack)  begin ord = ord * 4 + 3; nacks++; jt_req = 0; end
    end
    vid_req = 0; cpu_req = 0; jt_req = 0;
    check("collision order", ord, 32'h1B);
    check("collision double acks", multi, 0);
    check("collision data", {vid_data, cpu_rdata, 8'd0}, 32'h1357A500);
    check("collision jt data", {16'd0, jt_rdata}, 32'hC3E0);
    repeat (2) @(negedge clk24);

    // Starvation: video held high with the CPU waiting
    @(posedge clk24); #1;
    vid_req = 1; cpu_req = 1;
    vid_cnt = 0; cpu_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk24);
      if (vid_ack && !cpu_done) vid_cnt++;
      if (cpu_ack) begin cpu_done = 1; cpu_req = 0; end
    end
`ifdef SRAM_ARB_STARVE_GUARD_EN
    check("starve cpu granted", {31'd0, cpu_done}, 1);
    check("starve video grants first", vid_cnt, 4);
`else
    check("starve cpu blocked", {31'd0, cpu_done}, 0);
    check("starve video kept going", {31'd0, vid_cnt >= 10}, 1);
`endif
    vid_req = 0;
    for (int c = 0; c < 20 && !cpu_done; c++) begin
      @(negedge clk24);
      if (cpu_ack) begin cpu_done = 1; cpu_req = 0; end
    end
    cpu_req = 0;
    check("starve cpu served after video stops", {31'd0, cpu_done}, 1);
    repeat (3) @(negedge clk24);

    // RD_WAIT=3 instance: video read with long address hold
    b_vid_addr = 18'h00100;
    @(posedge clk24); #1;
    b_vid_req = 1;
    n = 0; stable = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk24); n++;
      @(negedge clk24);
      got = b_vid_ack;
      if (!got && b_sram_addr == 18'h00100 && b_sram_we_n) stable++;
    end
    b_vid_req = 0;
    check("rdwait3 latency", n, 5);
    check("rdwait3 addr stable cycles", stable, 4);
    check("rdwait3 data", {16'd0, b_vid_data}, 32'hBEEF);
    repeat (2) @(negedge clk24);

    // Reset asserted in the middle of a write pulse
    jt_we = 1; jt_addr = 18'h00055; jt_wdata = 16'h1111;
    @(posedge clk24); #1;
    jt_req = 1;
    repeat (2) @(posedge clk24);
    #2;
    check("mid-pulse we_n low", {31'd0, sram_we_n}, 0);
    reset_n = 1'b0;
    #1;
    check("abort strobes", {30'd0, sram_we_n, sram_dq_oe}, 32'h2);
    check("abort ub/lb/addr", {12'd0, sram_ub_n, sram_lb_n, sram_addr}, 32'hC0000);
    check("abort data", {vid_data, jt_rdata}, 0);
    jt_req = 0;
    nacks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk24);
      if (vid_ack || cpu_ack || jt_ack) nacks++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk24);
      if (vid_ack || cpu_ack || jt_ack || !sram_we_n) nacks++;
    end
    check("abort no ack", nacks, 0);
    check("abort cpu data", {24'd0, cpu_rdata}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Sequences the single 256K x 16 async SRAM between three requesters: video fetch (word reads), CPU (byte reads and writes in the 64K space plus ramdisk page), and JTAG/loader (word reads and writes).
- Sits between the CPU/video/JTAG front ends and the SRAM pins.
- Generates all SRAM strobes with defined setup, pulse and hold phases.
- Uses a per-requester req/ack handshake.

Parameters:
RD_WAIT, 1, extra cycles the address is held before read data is sampled (0..7).
STARVE_MAX, 4, consecutive video grants after which a waiting CPU must win (used only with SRAM_ARB_STARVE_GUARD_EN).

Ports:
clk24  in  1  system clock; all state changes on its rising edge
reset_n  in  1  asynchronous, active-low reset
vid_req  in  1  video read request, level, held until vid_ack
vid_addr  in  18  video word address
vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle
vid_data  out  16  video read word
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  16  CPU byte address
cpu_page  in  3  ramdisk page
cpu_wdata  in  8  CPU write byte
cpu_ack  out  1  one-cycle pulse
cpu_rdata  out  8  CPU read byte, valid with cpu_ack
jt_req  in  1  JTAG request, level
jt_we  in  1  1 = write
jt_addr  in  18  JTAG word address
jt_wdata  in  16  JTAG write word
jt_ack  out  1  one-cycle pulse
jt_rdata  out  16  JTAG read word, valid with jt_ack
sram_addr  out  18  SRAM address
sram_dq_o  out  16  SRAM write data
sram_dq_oe  out  1  1 = drive sram_dq_o onto the DQ pads
sram_dq_i  in  16  SRAM read data from pads
sram_we_n  out  1  write strobe
sram_ub_n  out  1  upper byte enable
sram_lb_n  out  1  lower byte enable

Behaviour:
- Reset (async, reset_n low): state IDLE; all acks 0; sram_we_n = 1; ub_n = lb_n = 1; dq_oe = 0; sram_addr = 0; data outputs 0; starve counter 0.
- Reset mid-operation aborts immediately: we_n deasserts and dq_oe drops asynchronously. No ack is issued for the aborted access.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE arbitration uses fixed priority vid > cpu > jt. The winner's address, byte enables, write data and direction are registered on the next edge, which enters RD or WR_SETUP.
- Simultaneous requests: exactly one is granted. Losers keep req high and are re-arbitrated on the next IDLE.
- CPU mapping:
  - sram_addr = {cpu_page, cpu_addr[15:1]}.
  - cpu_addr[0] = 1 selects the upper byte: ub_n = 0, lb_n = 1, write data on [15:8], read byte taken from [15:8].
  - cpu_addr[0] = 0 is the mirror case on [7:0].
  - For a CPU write, the undriven half of sram_dq_o is 0; only the enabled byte is written.
- Video and JTAG accesses use ub_n = lb_n = 0.
- RD: lasts RD_WAIT+1 cycles with we_n = 1 and dq_oe = 0. On its last cycle sram_dq_i is registered into the winner's data output, then the block enters ACK.
- WR_SETUP: address, byte enables and data driven, dq_oe = 1, we_n = 1.
- WR_PULSE: we_n = 0.
- WR_HOLD: we_n = 1, data and address still driven. Then ACK.
- ACK: exactly one cycle. The winner's ack = 1 and its read data is valid. Return to IDLE; dq_oe = 0 from ACK onward.
- Read latency, counting from the IDLE cycle where req is sampled: ack appears RD_WAIT+2 cycles later (3 at default).
- Write latency: ack 4 cycles after the IDLE sample.
- Requesters deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Data outputs hold their last value between acks.
- Address, byte enables and we_n change only while we_n = 1 (glitch-free strobes).

Optional Feature:
SRAM_ARB_STARVE_GUARD_EN
- Defined: a 3-bit counter increments on each video grant made while cpu_req = 1. It clears on any CPU grant or when cpu_req = 0.
- When the counter reaches STARVE_MAX, the next IDLE arbitration grants the CPU even if vid_req = 1.
- Undefined: pure fixed priority; the counter is absent.

Test Plan:
- Reset: reset_n low mid-WR_PULSE, then high -> we_n = 1 and dq_oe = 0 at once; no ack; state IDLE; all outputs 0 or 1 as specified.
- CPU byte write then read:
  - Write cpu_addr = 16'h1235, page = 3'd2, wdata = 8'hA5 -> sram_addr = 18'h1091A, ub_n = 0, lb_n = 1, dq_o = 16'hA500; we_n low exactly one cycle; cpu_ack 4 cycles after sample.
  - Read back with SRAM model -> cpu_rdata = 8'hA5 with ack 3 cycles after sample.
- Collision: vid_req, cpu_req and jt_req rise together -> order vid_ack, cpu_ack, jt_ack; never two acks in the same cycle.
- JTAG word write/read: jt_addr = 18'h3FFFF, wdata = 16'hC3E0 -> ub_n = lb_n = 0; read returns 16'hC3E0.
- RD_WAIT = 3: video read of 18'h00100 -> address stable 4 RD cycles; vid_ack 5 cycles after sample; vid_data matches model.
- Starve guard (macro defined): vid_req held high, cpu_req high -> CPU granted after exactly 4 video grants. Macro undefined -> CPU never granted while vid_req is held.
